baby_vga_fb_arbiter: RTL and testbench

- Single-port controller for the 16 x 32-bit monochrome framebuffer word store.
- Shares the store between the TinyQV peripheral bus and the display scanline fetcher.
- The fetcher posts one row read per 32 scanlines. The bus issues reads, and sub-word or full-word writes.
- The block arbitrates, sequences the fixed-latency read port, byte-masks writes and returns read data with handshakes.

---
 rtl/baby_vga_fb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_baby_vga_fb_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baby_vga_fb_arbiter.sv
// Framebuffer word-store arbiter: shares a single-port 16 x 32-bit store
// between the peripheral bus (byte/half/word reads and writes) and the
// scanline fetcher.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | port free, no op in progress
// ST_WR      | write strobe on the port this cycle (always one cycle)
// ST_RD_WAIT | read in flight, cnt_q counts down to the rdata sample
// ST_RESP    | response registered this cycle, port free
module baby_vga_fb_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    input  logic        line_req,
    input  logic [3:0]  line_idx,
    output logic [31:0] line_data,
    output logic        line_valid,
    output logic        line_miss,
    output logic        wr_overflow,
    output logic [3:0]  mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR      = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        disp_vld_q, disp_vld_d;
    logic [3:0]  disp_idx_q, disp_idx_d;

    logic        wb_vld_q, wb_vld_d;
    logic [3:0]  wb_addr_q, wb_addr_d;
    logic [3:0]  wb_be_q, wb_be_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;

    logic        rd_pend_q, rd_pend_d;
    logic        rd_out_q, rd_out_d;
    logic [5:0]  rd_addr_q, rd_addr_d;
    logic [1:0]  rd_size_q, rd_size_d;

    logic        fl_disp_q, fl_disp_d;
    logic [1:0]  fl_size_q, fl_size_d;
    logic [1:0]  fl_lane_q, fl_lane_d;

    logic [3:0]  mem_addr_q, mem_addr_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] data_out_q, data_out_d;
    logic        data_ready_q, data_ready_d;
    logic [31:0] line_data_q, line_data_d;
    logic        line_valid_q, line_valid_d;
    logic        line_miss_q, line_miss_d;
    logic        wr_ovf_q, wr_ovf_d;

    logic        wr_in;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        rd_sample;
    logic        port_free;
    logic        disp_any, wb_any, rd_any, rd_cap;
    logic        iss_disp, iss_wb, iss_rd;
    logic [3:0]  disp_sel_idx;
    logic [3:0]  wb_sel_addr, wb_sel_be;
    logic [31:0] wb_sel_wdata;
    logic [5:0]  rd_sel_addr;
    logic [1:0]  rd_sel_size;
    logic [31:0] rd_shift;
    logic [31:0] rd_fmt;

    // Lane placement of the incoming bus write.
    always_comb begin
        wr_in    = (data_write_n != 2'b11);
        in_be    = 4'b1111;
        in_wdata = data_in;
        case (data_write_n)
            2'b01: begin
                in_be    = address[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{data_in[15:0]}};
            end
            2'b00: begin
                in_be    = 4'b0001 << address[1:0];
                in_wdata = {4{data_in[7:0]}};
            end
            default: ;
        endcase
    end

    // Candidate selection and fixed-priority issue. A request arriving this
    // cycle is visible to the issue logic so it can capture and issue at once.
    always_comb begin
        rd_sample    = (state_q == ST_RD_WAIT) && (cnt_q == 3'd0);
        port_free    = (state_q != ST_RD_WAIT) || rd_sample;

        disp_any     = line_req || disp_vld_q;
        disp_sel_idx = line_req ? line_idx : disp_idx_q;

        wb_any       = wb_vld_q || wr_in;
        wb_sel_addr  = wb_vld_q ? wb_addr_q  : address[5:2];
        wb_sel_be    = wb_vld_q ? wb_be_q    : in_be;
        wb_sel_wdata = wb_vld_q ? wb_wdata_q : in_wdata;

        // The bus keeps its read asserted until data_ready, so an issued read
        // still blocks capture until its response pulse has gone by.
        rd_cap       = (data_read_n != 2'b11) && !rd_pend_q && !rd_out_q && !data_ready_q;
        rd_any       = rd_pend_q || rd_cap;
        rd_sel_addr  = rd_pend_q ? rd_addr_q : address;
        rd_sel_size  = rd_pend_q ? rd_size_q : data_read_n;

        iss_disp     = port_free && disp_any;
        iss_wb       = port_free && !disp_any && wb_any;
        iss_rd       = port_free && !disp_any && !wb_any && rd_any;
    end

    // Read response formatting: shift the lane down, then zero-extend.
    always_comb begin
        rd_shift = mem_rdata >> {fl_lane_q, 3'b000};
        case (fl_size_q)
            2'b00:   rd_fmt = {24'd0, rd_shift[7:0]};
            2'b01:   rd_fmt = {16'd0, rd_shift[15:0]};
            default: rd_fmt = mem_rdata;
        endcase
    end

    // Next-state for slots, port sequencer and registered outputs.
    always_comb begin
        disp_vld_d   = disp_any && !iss_disp;
        disp_idx_d   = disp_sel_idx;
        line_miss_d  = line_req && disp_vld_q;

        wb_vld_d     = wb_vld_q;
        wb_addr_d    = wb_addr_q;
        wb_be_d      = wb_be_q;
        wb_wdata_d   = wb_wdata_q;
        wr_ovf_d     = wr_ovf_q;
        if (iss_wb) begin
            wb_vld_d = wb_vld_q && wr_in;
            if (wb_vld_q && wr_in) begin
                wb_addr_d  = address[5:2];
                wb_be_d    = in_be;
                wb_wdata_d = in_wdata;
            end
        end else if (wr_in) begin
            if (wb_vld_q) begin
                wr_ovf_d = 1'b1;
            end else begin
                wb_vld_d   = 1'b1;
                wb_addr_d  = address[5:2];
                wb_be_d    = in_be;
                wb_wdata_d = in_wdata;
            end
        end

        rd_pend_d    = rd_any && !iss_rd;
        rd_addr_d    = rd_cap ? address : rd_addr_q;
        rd_size_d    = rd_cap ? data_read_n : rd_size_q;
        rd_out_d     = (rd_out_q && !(rd_sample && !fl_disp_q)) || iss_rd;

        state_d      = state_q;
        cnt_d        = cnt_q;
        fl_disp_d    = fl_disp_q;
        fl_size_d    = fl_size_q;
        fl_lane_d    = fl_lane_q;
        if (iss_disp || iss_rd) begin
            state_d   = ST_RD_WAIT;
            cnt_d     = 3'(MEM_LAT);
            fl_disp_d = iss_disp;
            fl_size_d = iss_disp ? 2'b10 : rd_sel_size;
            fl_lane_d = iss_disp ? 2'b00 : rd_sel_addr[1:0];
        end else if (iss_wb) begin
            state_d = ST_WR;
        end else if (rd_sample) begin
            state_d = ST_RESP;
        end else if (state_q == ST_WR || state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RD_WAIT) begin
            cnt_d = cnt_q - 3'd1;
        end

        mem_re_d     = iss_disp || iss_rd;
        mem_we_d     = iss_wb;
        mem_be_d     = iss_wb ? wb_sel_be : 4'b0000;
        mem_wdata_d  = iss_wb ? wb_sel_wdata : mem_wdata_q;
        mem_addr_d   = mem_addr_q;
        if (iss_disp) begin
            mem_addr_d = disp_sel_idx;
        end else if (iss_wb) begin
            mem_addr_d = wb_sel_addr;
        end else if (iss_rd) begin
            mem_addr_d = rd_sel_addr[5:2];
        end

        data_out_d   = data_out_q;
        data_ready_d = 1'b0;
        line_data_d  = line_data_q;
        line_valid_d = 1'b0;
        if (rd_sample) begin
            if (fl_disp_q) begin
                line_data_d  = mem_rdata;
                line_valid_d = 1'b1;
            end else begin
                data_out_d   = rd_fmt;
                data_ready_d = 1'b1;
            end
        end
    end

    // State registers; reset drops everything including in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            disp_vld_q   <= 1'b0;
            disp_idx_q   <= 4'd0;
            wb_vld_q     <= 1'b0;
            wb_addr_q    <= 4'd0;
            wb_be_q      <= 4'd0;
            wb_wdata_q   <= 32'd0;
            rd_pend_q    <= 1'b0;
            rd_out_q     <= 1'b0;
            rd_addr_q    <= 6'd0;
            rd_size_q    <= 2'd0;
            fl_disp_q    <= 1'b0;
            fl_size_q    <= 2'd0;
            fl_lane_q    <= 2'd0;
            mem_addr_q   <= 4'd0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            data_out_q   <= 32'd0;
            data_ready_q <= 1'b0;
            line_data_q  <= 32'd0;
            line_valid_q <= 1'b0;
            line_miss_q  <= 1'b0;
            wr_ovf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disp_vld_q   <= disp_vld_d;
            disp_idx_q   <= disp_idx_d;
            wb_vld_q     <= wb_vld_d;
            wb_addr_q    <= wb_addr_d;
            wb_be_q      <= wb_be_d;
            wb_wdata_q   <= wb_wdata_d;
            rd_pend_q    <= rd_pend_d;
            rd_out_q     <= rd_out_d;
            rd_addr_q    <= rd_addr_d;
            rd_size_q    <= rd_size_d;
            fl_disp_q    <= fl_disp_d;
            fl_size_q    <= fl_size_d;
            fl_lane_q    <= fl_lane_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            line_data_q  <= line_data_d;
            line_valid_q <= line_valid_d;
            line_miss_q  <= line_miss_d;
            wr_ovf_q     <= wr_ovf_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_ready  = data_ready_q;
    assign line_data   = line_data_q;
    assign line_valid  = line_valid_q;
    assign line_miss   = line_miss_q;
    assign wr_overflow = wr_ovf_q;
    assign mem_addr    = mem_addr_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_baby_vga_fb_arbiter.sv
// Directed bench for baby_vga_fb_arbiter with MEM_LAT=1: a behavioural word
// store, scoreboards for bus reads, display fetches and store writes, and
// cycle-exact checks of pulse timing.
module tb_baby_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        line_req = 1'b0;
    logic [3:0]  line_idx = '0;
    logic [31:0] line_data;
    logic        line_valid;
    logic        line_miss;
    logic        wr_overflow;
    logic [3:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_bus[$];
    logic [31:0] exp_line[$];
    logic [39:0] exp_wr[$];

    logic [31:0] mem[16];

    baby_vga_fb_arbiter #(.MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .line_req(line_req), .line_idx(line_idx), .line_data(line_data),
        .line_valid(line_valid), .line_miss(line_miss), .wr_overflow(wr_overflow),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'hDEADBEEF;
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // Store model: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_rdata <= 32'd0;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {18'd0, data_out, data_ready, line_data, line_valid, line_miss,
                wr_overflow, mem_addr, mem_re, mem_we, mem_be, mem_wdata};
    endfunction

    // Scoreboard side: compare every response/write against queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_ready) begin
                if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
                else chk("bus_data", data_out, exp_bus.pop_front());
            end
            if (line_valid) begin
                if (exp_line.size() == 0) chk("line_unexpected", 1, 0);
                else chk("line_data", line_data, exp_line.pop_front());
            end
            if (mem_we) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_port", {mem_addr, mem_be, mem_wdata}, exp_wr.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] e);
        logic got;
        got = 1'b0;
        exp_bus.push_back(e);
        tick();
        data_write_n = 2'b11;
        line_req     = 1'b0;
        address      = a;
        data_read_n  = sz;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (data_ready) begin
                got = 1'b1;
                break;
            end
        end
        data_read_n = 2'b11;
        chk("rd_done", got, 1'b1);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outs", all_outs(), 128'd0);
        rst = 1'b0;
        tick();

        // Idle word read at index 3.
        tick();
        address = 6'h0C;
        data_read_n = 2'b10;
        exp_bus.push_back(32'hDEADBEEF);
        tick();
        chk("t1_re_c1", {mem_re, mem_addr}, {1'b1, 4'd3});
        chk("t1_rdy_c1", data_ready, 1'b0);
        tick();
        chk("t1_re_c2", mem_re, 1'b0);
        chk("t1_rdy_c2", data_ready, 1'b0);
        tick();
        chk("t1_rdy_c3", data_ready, 1'b1);
        chk("t1_dout_c3", data_out, 32'hDEADBEEF);
        data_read_n = 2'b11;
        tick();
        chk("t1_rdy_c4", data_ready, 1'b0);
        chk("t1_hold_c4", data_out, 32'hDEADBEEF);

        // Byte write then byte/half reads of the same word.
        tick();
        data_write_n = 2'b00;
        address = 6'h06;
        data_in = 32'h000000A5;
        exp_wr.push_back({4'd1, 4'b0100, 32'hA5A5A5A5});
        tick();
        data_write_n = 2'b11;
        chk("t2_we", mem_we, 1'b1);
        chk("t2_be", mem_be, 4'b0100);
        chk("t2_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("t2_addr", mem_addr, 4'd1);
        do_read(6'h06, 2'b00, 32'h000000A5);
        do_read(6'h06, 2'b01, 32'h0000C0A5);
        do_read(6'h07, 2'b00, 32'h000000C0);
        do_read(6'h04, 2'b01, 32'h00000001);

        // Upper half write then word read back.
        tick();
        data_write_n = 2'b01;
        address = 6'h2A;
        data_in = 32'h1234BEEF;
        exp_wr.push_back({4'd10, 4'b1100, 32'hBEEFBEEF});
        do_read(6'h28, 2'b10, 32'hBEEF000A);

        // Display fetch and bus read in the same cycle.
        tick();
        line_req = 1'b1;
        line_idx = 4'd7;
        address = 6'h10;
        data_read_n = 2'b10;
        exp_line.push_back(32'hC0DE0007);
        exp_bus.push_back(32'hC0DE0004);
        for (int c = 1; c <= 5; c++) begin
            tick();
            line_req = 1'b0;
            chk("t3_line_valid", line_valid, 1'(c == 3));
            chk("t3_data_ready", data_ready, 1'(c == 5));
        end
        data_read_n = 2'b11;

        // Write immediately followed by a read of the same word.
        tick();
        data_write_n = 2'b10;
        address = 6'h08;
        data_in = 32'h12345678;
        exp_wr.push_back({4'd2, 4'b1111, 32'h12345678});
        do_read(6'h08, 2'b10, 32'h12345678);

        // Two writes while a display read is in flight: second one dropped.
        tick();
        line_req = 1'b1;
        line_idx = 4'd2;
        data_write_n = 2'b10;
        address = 6'h14;
        data_in = 32'h11111111;
        exp_line.push_back(32'h12345678);
        exp_wr.push_back({4'd5, 4'b1111, 32'h11111111});
        tick();
        line_req = 1'b0;
        address = 6'h18;
        data_in = 32'h22222222;
        chk("t5_ovf_c1", wr_overflow, 1'b0);
        tick();
        data_write_n = 2'b11;
        chk("t5_ovf_c2", wr_overflow, 1'b1);
        repeat (4) tick();
        chk("t5_ovf_sticky", wr_overflow, 1'b1);
        do_read(6'h18, 2'b10, 32'hC0DE0006);
        do_read(6'h14, 2'b10, 32'h11111111);

        // Back-to-back line requests while the port is busy.
        tick();
        line_req = 1'b1;
        line_idx = 4'd8;
        exp_line.push_back(32'hC0DE0008);
        exp_line.push_back(32'hC0DE000B);
        tick();
        line_idx = 4'd9;
        chk("t6_miss_c1", line_miss, 1'b0);
        tick();
        line_idx = 4'd11;
        chk("t6_miss_c2", line_miss, 1'b0);
        for (int c = 3; c <= 7; c++) begin
            tick();
            line_req = 1'b0;
            chk("t6_miss", line_miss, 1'(c == 3));
            chk("t6_valid", line_valid, 1'(c == 3 || c == 5));
        end

        // Reset while a bus read is in flight.
        tick();
        address = 6'h0C;
        data_read_n = 2'b10;
        tick();
        chk("t7_re_c1", mem_re, 1'b1);
        chk("t7_ovf_before", wr_overflow, 1'b1);
        tick();
        rst = 1'b1;
        data_read_n = 2'b11;
        tick();
        chk("t7_outs_reset", all_outs(), 128'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t7_no_pulse", {data_ready, line_valid, wr_overflow}, 3'b000);
        end

        chk("q_bus_empty", 32'(exp_bus.size()), 32'd0);
        chk("q_line_empty", 32'(exp_line.size()), 32'd0);
        chk("q_wr_empty", 32'(exp_wr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
